// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal entry block.
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [3:0]  DIGIT_MAX = 4'd9;
  localparam logic [31:0] VALUE_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/decimal_entry_debounce.sv
// Debouncer for one active-low pushbutton: 2-flop synchroniser, stability
// counter and a one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_WIDTH        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [DB_WIDTH-1:0] CNT_LIMIT = DB_WIDTH'(DEBOUNCE_CYCLES);

  logic                sync1_q;
  logic                sync2_q;
  logic                stable_q;
  logic                press_q;
  logic [DB_WIDTH-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LIMIT) begin
        // New level accepted; only the released-to-pressed edge emits a pulse.
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + DB_WIDTH'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/decimal_entry.sv
// Operator decimal entry: builds a 32-bit value from debounced digit presses
// and hands it to the processor through a request/valid/ack handshake.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_WIDTH        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic        key_digit,
  input  logic        key_clear,
  input  logic        key_enter,
  input  logic        request,
  input  logic        ack,
  output logic [31:0] value,
  output logic        valid,
  output logic        waiting
);

  logic digit_ev;
  logic clear_ev;
  logic enter_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_digit (
    .clock(clock), .reset(reset), .key_n_i(key_digit), .press_o(digit_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_clear (
    .clock(clock), .reset(reset), .key_n_i(key_clear), .press_o(clear_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_enter (
    .clock(clock), .reset(reset), .key_n_i(key_enter), .press_o(enter_ev)
  );

  state_e      state_q;
  logic [31:0] value_q;
  logic        valid_q;
  logic        waiting_q;

  logic [35:0] value_ext;
  logic [35:0] product_d;
  logic        digit_ok;

  always_comb begin
    value_ext = {4'b0, value_q};
    product_d = (value_ext << 3) + (value_ext << 1) + {32'b0, digit};
    digit_ok  = (digit <= DIGIT_MAX) && (product_d <= {4'b0, VALUE_MAX});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      value_q   <= '0;
      valid_q   <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            state_q   <= COLLECT;
            value_q   <= '0;
            waiting_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (!request) begin
            state_q   <= IDLE;
            waiting_q <= 1'b0;
          end else if (clear_ev) begin
            value_q <= '0;
          end else if (enter_ev) begin
            state_q   <= DONE;
            valid_q   <= 1'b1;
            waiting_q <= 1'b0;
          end else if (digit_ev && digit_ok) begin
            value_q <= product_d[31:0];
          end
        end
        DONE: begin
          if (ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          valid_q   <= 1'b0;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign waiting = waiting_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Bench for decimal_entry with a short debounce window and a reference model
// of the entry rules tracking the expected value/valid/waiting.
module tb_decimal_entry;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit = 4'd0;
  logic        key_digit = 1'b1;
  logic        key_clear = 1'b1;
  logic        key_enter = 1'b1;
  logic        request = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] value;
  logic        valid;
  logic        waiting;

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned ref_val   = 0;
  bit              ref_valid = 1'b0;
  bit              ref_wait  = 1'b0;

  decimal_entry #(.DEBOUNCE_CYCLES(4), .DB_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .digit(digit),
    .key_digit(key_digit), .key_clear(key_clear), .key_enter(key_enter),
    .request(request), .ack(ack),
    .value(value), .valid(valid), .waiting(waiting)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference rules: clear beats enter beats digit; digits > 9 or results
  // beyond 32 bits are dropped; nothing happens outside entry.
  function automatic void model_press(input bit kd, input bit kc, input bit ke, input logic [3:0] d);
    longint unsigned nxt;
    nxt = ref_val * 10 + longint'(d);
    if (ref_wait) begin
      if (kc) ref_val = 0;
      else if (ke) begin
        ref_valid = 1'b1;
        ref_wait  = 1'b0;
      end else if (kd && d <= 9 && nxt <= 64'hFFFF_FFFF) ref_val = nxt;
    end
  endfunction

  task automatic press(input bit kd, input bit kc, input bit ke, input logic [3:0] d);
    digit     = d;
    key_digit = !kd;
    key_clear = !kc;
    key_enter = !ke;
    cyc(12);
    key_digit = 1'b1;
    key_clear = 1'b1;
    key_enter = 1'b1;
    cyc(12);
    model_press(kd, kc, ke, d);
  endtask

  task automatic start_entry();
    request = 1'b1;
    cyc(2);
    ref_val   = 0;
    ref_wait  = 1'b1;
    ref_valid = 1'b0;
  endtask

  task automatic finish_ack(input bit keep_request);
    ack     = 1'b1;
    request = keep_request;
    cyc(1);
    ack       = 1'b0;
    ref_valid = 1'b0;
    n_cmp++;
    if ({value, valid, waiting} !== {ref_val[31:0], ref_valid, ref_wait}) begin
      n_err++;
      $display("FAIL ack_release: value=%0d valid=%b waiting=%b expected %0d %b %b",
               value, valid, waiting, ref_val, ref_valid, ref_wait);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    n_cmp++;
    if ({value, valid, waiting} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_state: value=%0d valid=%b waiting=%b expected 0 0 0", value, valid, waiting);
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic();
    logic [3:0] seq [4] = '{4'd4, 4'd0, 4'd9, 4'd5};
    start_entry();
    n_cmp++;
    if ({value, valid, waiting} !== {32'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL collect_entry: value=%0d valid=%b waiting=%b expected 0 0 1", value, valid, waiting);
    end
    for (int i = 0; i < 4; i++) begin
      // The last press is enter; the digit lines stay idle for it.
      if (i == 3) press(1'b0, 1'b0, 1'b1, seq[i]);
      else        press(1'b1, 1'b0, 1'b0, seq[i]);
      n_cmp++;
      if ({value, valid, waiting} !== {ref_val[31:0], ref_valid, ref_wait}) begin
        n_err++;
        $display("FAIL basic_step%0d: value=%0d valid=%b waiting=%b expected %0d %b %b",
                 i, value, valid, waiting, ref_val, ref_valid, ref_wait);
      end
    end
    n_cmp++;
    if ({value, valid, waiting} !== {32'd409, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL basic_commit: value=%0d valid=%b waiting=%b expected 409 1 0", value, valid, waiting);
    end
    press(1'b1, 1'b0, 1'b0, 4'd5);
    n_cmp++;
    if ({value, valid} !== {32'd409, 1'b1}) begin
      n_err++;
      $display("FAIL done_frozen: value=%0d valid=%b expected 409 1", value, valid);
    end
    finish_ack(1'b0);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(2);
    n_cmp++;
    if ({value, valid, waiting} !== {32'd409, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL idle_ack_ignored: value=%0d valid=%b waiting=%b expected 409 0 0", value, valid, waiting);
    end
  endtask

  task automatic test_max();
    logic [3:0] digs [10] = '{4'd4, 4'd2, 4'd9, 4'd4, 4'd9, 4'd6, 4'd7, 4'd2, 4'd9, 4'd5};
    start_entry();
    foreach (digs[i]) begin
      press(1'b1, 1'b0, 1'b0, digs[i]);
      n_cmp++;
      if (value !== ref_val[31:0]) begin
        n_err++;
        $display("FAIL max_digit%0d: value=%0d expected %0d", i, value, ref_val);
      end
    end
    n_cmp++;
    if (value !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL max_value: value=%0d expected 4294967295", value);
    end
    press(1'b1, 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (value !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL overflow_drop: value=%0d expected 4294967295", value);
    end
    press(1'b0, 1'b0, 1'b1, 4'd0);
    n_cmp++;
    if ({value, valid, waiting} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL max_commit: value=%0d valid=%b waiting=%b expected 4294967295 1 0", value, valid, waiting);
    end
    finish_ack(1'b1);
    cyc(1);
    ref_val  = 0;
    ref_wait = 1'b1;
    n_cmp++;
    if ({value, valid, waiting} !== {32'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rerequest: value=%0d valid=%b waiting=%b expected 0 0 1", value, valid, waiting);
    end
  endtask

  task automatic test_digit_range();
    press(1'b1, 1'b0, 1'b0, 4'd1);
    press(1'b1, 1'b0, 1'b0, 4'd2);
    press(1'b1, 1'b0, 1'b0, 4'hA);
    n_cmp++;
    if (value !== 32'd12) begin
      n_err++;
      $display("FAIL non_bcd_drop: value=%0d expected 12", value);
    end
    press(1'b0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (value !== 32'd0) begin
      n_err++;
      $display("FAIL clear: value=%0d expected 0", value);
    end
    press(1'b1, 1'b0, 1'b0, 4'd7);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
    n_cmp++;
    if ({value, valid, waiting} !== {32'd7, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL collect_ack_ignored: value=%0d valid=%b waiting=%b expected 7 0 1", value, valid, waiting);
    end
    press(1'b0, 1'b0, 1'b1, 4'd0);
    n_cmp++;
    if ({value, valid, waiting} !== {ref_val[31:0], ref_valid, ref_wait} || value !== 32'd7) begin
      n_err++;
      $display("FAIL commit7: value=%0d valid=%b waiting=%b expected 7 1 0", value, valid, waiting);
    end
    finish_ack(1'b0);
  endtask

  task automatic test_bounce();
    start_entry();
    digit = 4'd3;
    key_digit = 1'b0; cyc(2);
    key_digit = 1'b1; cyc(2);
    key_digit = 1'b0; cyc(3);
    key_digit = 1'b1; cyc(1);
    key_digit = 1'b0; cyc(1);
    key_digit = 1'b1; cyc(12);
    n_cmp++;
    if (value !== 32'd0) begin
      n_err++;
      $display("FAIL bounce_reject: value=%0d expected 0", value);
    end
    key_digit = 1'b0;
    cyc(20);
    ref_val = 3;
    n_cmp++;
    if (value !== 32'd3) begin
      n_err++;
      $display("FAIL held_once: value=%0d expected 3", value);
    end
    cyc(10);
    key_digit = 1'b1;
    cyc(12);
    n_cmp++;
    if (value !== 32'd3) begin
      n_err++;
      $display("FAIL held_release: value=%0d expected 3", value);
    end
    press(1'b1, 1'b0, 1'b0, 4'd3);
    n_cmp++;
    if (value !== 32'd33) begin
      n_err++;
      $display("FAIL repress: value=%0d expected 33", value);
    end
  endtask

  task automatic test_same_cycle();
    press(1'b0, 1'b1, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0, 4'd5);
    press(1'b1, 1'b0, 1'b0, 4'd5);
    press(1'b0, 1'b1, 1'b1, 4'd0);
    n_cmp++;
    if ({value, valid, waiting} !== {32'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL clear_beats_enter: value=%0d valid=%b waiting=%b expected 0 0 1", value, valid, waiting);
    end
    press(1'b1, 1'b0, 1'b0, 4'd5);
    press(1'b1, 1'b0, 1'b0, 4'd5);
    press(1'b1, 1'b0, 1'b1, 4'd8);
    n_cmp++;
    if ({value, valid, waiting} !== {32'd55, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL enter_beats_digit: value=%0d valid=%b waiting=%b expected 55 1 0", value, valid, waiting);
    end
    finish_ack(1'b0);
  endtask

  task automatic test_request_drop();
    start_entry();
    press(1'b1, 1'b0, 1'b0, 4'd6);
    request = 1'b0;
    cyc(2);
    ref_wait = 1'b0;
    n_cmp++;
    if ({value, valid, waiting} !== {32'd6, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL request_drop: value=%0d valid=%b waiting=%b expected 6 0 0", value, valid, waiting);
    end
  endtask

  task automatic test_random();
    bit kd, kc, ke;
    logic [3:0] d;
    for (int round = 0; round < 2; round++) begin
      start_entry();
      for (int i = 0; i < 30; i++) begin
        kd = ($urandom_range(0, 9) != 0);
        kc = ($urandom_range(0, 11) == 0);
        ke = 1'b0;
        if (!kd && !kc) kc = 1'b1;
        d = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        press(kd, kc, ke, d);
        n_cmp++;
        if ({value, valid, waiting} !== {ref_val[31:0], ref_valid, ref_wait}) begin
          n_err++;
          $display("FAIL random_r%0d_p%0d: value=%0d valid=%b waiting=%b expected %0d %b %b",
                   round, i, value, valid, waiting, ref_val, ref_valid, ref_wait);
        end
      end
      press(1'b0, 1'b0, 1'b1, 4'd0);
      n_cmp++;
      if ({value, valid, waiting} !== {ref_val[31:0], 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL random_commit%0d: value=%0d valid=%b waiting=%b expected %0d 1 0",
                 round, value, valid, waiting, ref_val);
      end
      finish_ack(1'b0);
    end
  endtask

  task automatic test_async_reset();
    start_entry();
    press(1'b1, 1'b0, 1'b0, 4'd9);
    press(1'b1, 1'b0, 1'b0, 4'd9);
    press(1'b0, 1'b0, 1'b1, 4'd0);
    n_cmp++;
    if ({value, valid, waiting} !== {32'd99, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL pre_reset_done: value=%0d valid=%b waiting=%b expected 99 1 0", value, valid, waiting);
    end
    request = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    ref_val = 0; ref_valid = 1'b0; ref_wait = 1'b0;
    n_cmp++;
    if ({value, valid, waiting} !== 34'd0) begin
      n_err++;
      $display("FAIL async_reset: value=%0d valid=%b waiting=%b expected 0 0 0", value, valid, waiting);
    end
    #1 reset = 1'b0;
    cyc(2);
    press(1'b1, 1'b0, 1'b0, 4'd5);
    press(1'b0, 1'b0, 1'b1, 4'd0);
    n_cmp++;
    if ({value, valid, waiting} !== {ref_val[31:0], ref_valid, ref_wait}) begin
      n_err++;
      $display("FAIL idle_keys_ignored: value=%0d valid=%b waiting=%b expected 0 0 0", value, valid, waiting);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_digit_range();
    test_bounce();
    test_same_cycle();
    test_request_drop();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decimal_entry.md
Name: decimal_entry

Overview:
- Operator-input counterpart to the seven-segment output path.
- Builds a 32-bit unsigned number from decimal digits on 4 switches and pushbutton presses, and hands it to the processor's input instruction through a request/valid/ack handshake.
- Exposes the partially entered value live so the display driver can echo it while the operator types.

Parameters:
- DEBOUNCE_CYCLES, 50000, clock cycles a raw button level must stay stable before it is accepted (1 ms at 50 MHz).
- DB_WIDTH, 16, width of the debounce counter; must satisfy 2^DB_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- digit  in  4  BCD digit from switches; sampled at the accepted press of key_digit.
- key_digit  in  1  raw button, active-low: append digit.
- key_clear  in  1  raw button, active-low: zero the entry.
- key_enter  in  1  raw button, active-low: commit the entry.
- request  in  1  processor is waiting on an input instruction; level-held until ack.
- ack  in  1  one-cycle pulse from processor: value has been consumed.
- value  out  32  current entry (live during COLLECT, frozen during DONE).
- valid  out  1  committed value available.
- waiting  out  1  block is in COLLECT (drives an "enter number" LED).

Behaviour:
- Reset (async, active-high): state=IDLE, value=0, valid=0, waiting=0, all debouncers stable-released, counters=0.
- Debounce, per key:
  - Synchronise the raw input through 2 flops.
  - Count while the synced level differs from the stable level; clear the counter when they match.
  - At DEBOUNCE_CYCLES, take the new stable level.
  - A press event is a one-cycle pulse on the stable high-to-low transition only.
  - Press latency from raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: press events are ignored. On request=1, go to COLLECT next cycle with value=0 and waiting=1.
  - COLLECT, digit event:
    - If digit > 9, ignore the press.
    - Otherwise compute value*10 + digit in 36 bits as (value<<3)+(value<<1)+digit.
    - If the result exceeds 32'hFFFFFFFF, ignore the press; value is unchanged (no wrap, no saturation).
    - Otherwise load the result into value on the next edge.
  - COLLECT, clear event: value <= 0.
  - COLLECT, enter event: go to DONE; valid <= 1, waiting <= 0, value frozen.
  - COLLECT, request drops before enter: return to IDLE, waiting <= 0, value kept.
  - DONE: hold valid=1 and value stable regardless of key events. On ack=1, go to IDLE with valid <= 0 next cycle; value is retained for display.
- Priority when several press events fall on the same cycle in COLLECT: clear > enter > digit. Clear wins alone; enter commits the pre-cycle value; the digit is dropped.
- An ack outside DONE is ignored. A request held high after ack starts a fresh COLLECT one cycle after IDLE is re-entered.
- A button held down produces exactly one event; re-arming requires a debounced release.
- Reset mid-entry or while in DONE aborts immediately to the reset values; no partial handshake survives.

Decomposition:
- Shared package/include holds:
  - State encodings IDLE=0, COLLECT=1, DONE=2 (2 bits).
  - The DIGIT_MAX=9 constant.
  - The 32-bit maximum value constant.
- One sub-module, key_debounce: synchroniser, counter and falling-edge pulse, parameterised by DEBOUNCE_CYCLES and DB_WIDTH. It is instantiated three times.
- The multiply-by-10 stays inline, built from shifts and adds.

Test Plan:
1. Benches use DEBOUNCE_CYCLES=4. Reset, then request=1; press digits 4, 0, 9, then enter -> value=409, valid=1, waiting=0. Pulse ack -> valid=0 next cycle, state IDLE.
2. In COLLECT, enter 4294967295 digit by digit -> value=4294967295. Press digit 0 -> value unchanged, and enter still commits 4294967295.
3. Enter 12; set digit=4'hA and press -> value=12. Press clear -> value=0. Press 7, then enter -> value=7.
4. Bounce key_digit with digit=3 (pulses shorter than 4 cycles), then hold it low for 20 cycles -> value increments exactly once, to 3. No further change until release and re-press.
5. Same-cycle clear and enter press events with value=55 -> value=0 and state stays COLLECT. Same-cycle enter and digit=8 with value=55 -> valid=1, value=55.
6. Assert reset asynchronously (between clock edges) while in DONE with value=99 -> valid=0, waiting=0, value=0 before the next clock edge. Key presses with request=0 -> no change.
